// File: rtl/mipi_csi_pkg.sv
// Shared constants and types for the CSI frame controller.
//   SYNC_BYTE       : byte0 value of the word that precedes every packet header
//   DI_*            : data identifiers the controller reacts to (virtual channel 0)
//   state_t         : frame-level FSM encoding
//   ERR_*           : bit positions inside err_o
//   is_long_dt      : true for CSI data types that carry a payload
package mipi_csi_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic [7:0] DI_FS     = 8'h00;
    localparam logic [7:0] DI_FE     = 8'h01;
    localparam logic [7:0] DI_RAW10  = 8'h2B;
    localparam logic [7:0] DI_RAW12  = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_FRAME   = 2'd2,
        ST_SKIP    = 2'd3
    } state_t;

    localparam int ERR_FS_IN_FRAME = 0;  // FS arrived while a frame was open
    localparam int ERR_FE_NO_FS    = 1;  // FE arrived while waiting for FS
    localparam int ERR_LINE_COUNT  = 2;  // line count at FE differs from expectation
    localparam int ERR_TRUNC       = 3;  // burst ended inside a long-packet payload

    // CSI data types 0x00..0x0F are short packets; everything above has a payload.
    function automatic logic is_long_dt(input logic [5:0] dt);
        return dt >= 6'h10;
    endfunction

endpackage

// File: rtl/mipi_csi_header_detector.sv
// Finds packet headers in the lane-aligned word stream and skips long-packet
// payloads so payload bytes are never mistaken for a sync word.
//   clk_i, reset_n_i : byte clock, async active-low reset
//   data_valid_i     : word valid (HS burst active)
//   data_i           : lane-aligned word, byte0 in [7:0]
//   hdr_valid        : current word is a packet header (combinational)
//   di, wc           : data identifier and word count fields of the current word
//   trunc_err        : burst ended while payload words were still outstanding
module mipi_csi_header_detector
    import mipi_csi_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        hdr_valid,
    output logic [7:0]  di,
    output logic [15:0] wc,
    output logic        trunc_err
);

    logic        sync_seen;
    logic [16:0] remaining;
    logic [16:0] payload_words;
    logic        skipping;
    logic        unused_ecc;

    assign di        = data_i[7:0];
    assign wc        = data_i[23:8];
    assign skipping  = (remaining != 17'd0);
    assign hdr_valid = data_valid_i && sync_seen && !skipping;
    assign trunc_err = !data_valid_i && skipping;
    assign unused_ecc = ^data_i[31:24];

    // Payload plus 2-byte CRC, rounded up to whole words.
    assign payload_words = ({1'b0, wc} + 17'd2 + 17'(LANES - 1)) / 17'(LANES);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_seen <= 1'b0;
            remaining <= '0;
        end else if (!data_valid_i) begin
            // End of HS burst: any pending payload is lost, sync tracking restarts.
            sync_seen <= 1'b0;
            remaining <= '0;
        end else if (skipping) begin
            sync_seen <= 1'b0;
            remaining <= remaining - 17'd1;
        end else begin
            // A header word is consumed as a header, never as a new sync word.
            sync_seen <= !hdr_valid && (di == SYNC_BYTE);
            if (hdr_valid && is_long_dt(di[5:0])) begin
                remaining <= payload_words;
            end
        end
    end

endmodule

// File: rtl/mipi_csi_frame_controller.sv
// Frame-level sequencer for the CSI packet-decoding datapath: forwards one of
// every (frame_skip_i+1) frames by gating the decoder, counts lines and frames,
// and keeps sticky protocol-error flags.
//   clk_i, reset_n_i  : byte clock, async active-low reset
//   data_valid_i/data_i : lane-aligned word stream (shared with the decoder)
//   enable_i          : controller enable, honoured only between frames
//   frame_skip_i      : decimation factor, sampled at FS
//   expected_lines_i  : expected lines per frame (0 = no check), sampled at FE
//   clear_err_i       : clears err_o (a simultaneous new error still sets)
//   decoder_enable_o  : decoder output gate, high while a forwarded frame is open
//   frame_start_o/frame_end_o/line_start_o : one-cycle event pulses
//   line_count_o, frame_count_o : counters, err_o : sticky errors
//   state_o           : FSM state for debug/observation
// All outputs are registered: an event on header word at cycle t shows at t+1.
module mipi_csi_frame_controller
    import mipi_csi_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int MAX_SKIP_W = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  data_valid_i,
    input  logic [31:0]           data_i,
    input  logic                  enable_i,
    input  logic [MAX_SKIP_W-1:0] frame_skip_i,
    input  logic [15:0]           expected_lines_i,
    input  logic                  clear_err_i,
    output logic                  decoder_enable_o,
    output logic                  frame_start_o,
    output logic                  frame_end_o,
    output logic                  line_start_o,
    output logic [15:0]           line_count_o,
    output logic [15:0]           frame_count_o,
    output logic [3:0]            err_o,
    output state_t                state_o
);

    logic        hdr_valid;
    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc_unused;
    logic        trunc_err;

    mipi_csi_header_detector #(.LANES(LANES)) u_hdr (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .hdr_valid    (hdr_valid),
        .di           (hdr_di),
        .wc           (hdr_wc_unused),
        .trunc_err    (trunc_err)
    );

    logic is_fs, is_fe, is_line;
    assign is_fs   = hdr_valid && (hdr_di == DI_FS);
    assign is_fe   = hdr_valid && (hdr_di == DI_FE);
    assign is_line = hdr_valid && ((hdr_di == DI_RAW10) || (hdr_di == DI_RAW12));

    state_t                state, state_n;
    logic [MAX_SKIP_W-1:0] skip_cnt, skip_n;
    logic                  dec_en_n, fs_n, fe_n, ls_n;
    logic [15:0]           lc_n, fc_n;
    logic [3:0]            err_set, err_n;

    assign state_o = state;

    always_comb begin
        state_n  = state;
        skip_n   = skip_cnt;
        dec_en_n = decoder_enable_o;
        fs_n     = 1'b0;
        fe_n     = 1'b0;
        ls_n     = 1'b0;
        lc_n     = line_count_o;
        fc_n     = frame_count_o;
        err_set  = '0;
        err_set[ERR_TRUNC] = trunc_err;

        case (state)
            ST_IDLE: begin
                dec_en_n = 1'b0;
                if (enable_i) state_n = ST_WAIT_FS;
            end
            ST_WAIT_FS: begin
                if (!enable_i) begin
                    state_n = ST_IDLE;
                end else if (is_fs) begin
                    if (skip_cnt == '0) begin
                        state_n  = ST_FRAME;
                        skip_n   = frame_skip_i;
                        fs_n     = 1'b1;
                        lc_n     = '0;
                        dec_en_n = 1'b1;
                    end else begin
                        state_n = ST_SKIP;
                        skip_n  = skip_cnt - MAX_SKIP_W'(1);
                    end
                end else if (is_fe) begin
                    err_set[ERR_FE_NO_FS] = 1'b1;
                end
            end
            ST_FRAME: begin
                if (is_line) begin
                    ls_n = 1'b1;
                    if (line_count_o != 16'hFFFF) lc_n = line_count_o + 16'd1;
                end else if (is_fe) begin
                    fe_n     = 1'b1;
                    fc_n     = frame_count_o + 16'd1;
                    dec_en_n = 1'b0;
                    state_n  = enable_i ? ST_WAIT_FS : ST_IDLE;
                    if ((expected_lines_i != 16'd0) && (line_count_o != expected_lines_i))
                        err_set[ERR_LINE_COUNT] = 1'b1;
                end else if (is_fs) begin
                    // Missing FE: close the old frame implicitly and open a new one.
                    err_set[ERR_FS_IN_FRAME] = 1'b1;
                    fs_n   = 1'b1;
                    lc_n   = '0;
                    fc_n   = frame_count_o + 16'd1;
                    skip_n = frame_skip_i;
                end
            end
            ST_SKIP: begin
                dec_en_n = 1'b0;
                if (is_fe) begin
                    state_n = enable_i ? ST_WAIT_FS : ST_IDLE;
                end else if (is_fs) begin
                    err_set[ERR_FS_IN_FRAME] = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        err_n = (clear_err_i ? 4'b0000 : err_o) | err_set;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state            <= ST_IDLE;
            skip_cnt         <= '0;
            decoder_enable_o <= 1'b0;
            frame_start_o    <= 1'b0;
            frame_end_o      <= 1'b0;
            line_start_o     <= 1'b0;
            line_count_o     <= '0;
            frame_count_o    <= '0;
            err_o            <= '0;
        end else begin
            state            <= state_n;
            skip_cnt         <= skip_n;
            decoder_enable_o <= dec_en_n;
            frame_start_o    <= fs_n;
            frame_end_o      <= fe_n;
            line_start_o     <= ls_n;
            line_count_o     <= lc_n;
            frame_count_o    <= fc_n;
            err_o            <= err_n;
        end
    end

endmodule

// File: tb/tb_mipi_csi_frame_controller.sv
// Directed bench for mipi_csi_frame_controller. Inputs change 1 ns after the
// rising edge; outputs are checked at the same point, so each check sees the
// registered result of the word consumed at the preceding edge.
module tb_mipi_csi_frame_controller;
    import mipi_csi_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        enable_i = 1'b0;
    logic [3:0]  frame_skip_i = '0;
    logic [15:0] expected_lines_i = '0;
    logic        clear_err_i = 1'b0;
    logic        decoder_enable_o, frame_start_o, frame_end_o, line_start_o;
    logic [15:0] line_count_o, frame_count_o;
    logic [3:0]  err_o;
    state_t      state_o;

    int checks = 0;
    int errors = 0;
    int fs_pulses = 0, fe_pulses = 0, ls_pulses = 0;
    int base_fe, base_ls;

    mipi_csi_frame_controller #(.LANES(4), .MAX_SKIP_W(4)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .data_valid_i     (data_valid_i),
        .data_i           (data_i),
        .enable_i         (enable_i),
        .frame_skip_i     (frame_skip_i),
        .expected_lines_i (expected_lines_i),
        .clear_err_i      (clear_err_i),
        .decoder_enable_o (decoder_enable_o),
        .frame_start_o    (frame_start_o),
        .frame_end_o      (frame_end_o),
        .line_start_o     (line_start_o),
        .line_count_o     (line_count_o),
        .frame_count_o    (frame_count_o),
        .err_o            (err_o),
        .state_o          (state_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (frame_start_o) fs_pulses++;
        if (frame_end_o)   fe_pulses++;
        if (line_start_o)  ls_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        data_valid_i = v;
        data_i       = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc);
        drive(1'b1, 32'h0000_00B8);
        drive(1'b1, {8'h00, wc, di});
    endtask

    // Payload words deliberately carry 0xB8 in byte0 to look like sync words.
    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 32'hA5A5_01B8);
    endtask

    task automatic do_reset();
        reset_n_i    = 1'b0;
        data_valid_i = 1'b0;
        data_i       = '0;
        clear_err_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {28'd0, decoder_enable_o, frame_start_o, frame_end_o, line_start_o}, 32'd0);
        check({tag, "_lc"}, {16'd0, line_count_o}, 32'd0);
        check({tag, "_fc"}, {16'd0, frame_count_o}, 32'd0);
        check({tag, "_err"}, {28'd0, err_o}, 32'd0);
        check({tag, "_state"}, 32'(state_o), 32'(ST_IDLE));
    endtask

    initial begin
        // Reset state
        do_reset();
        check_all_zero("reset");

        // Test 1: basic forwarded frame, 3 RAW10 lines of WC=8 (3 payload words each)
        enable_i = 1'b1; frame_skip_i = 4'd0; expected_lines_i = 16'd3;
        drive(1'b0, '0);
        check("t1_wait_fs", 32'(state_o), 32'(ST_WAIT_FS));
        check("t1_den_before_fs", {31'd0, decoder_enable_o}, 32'd0);
        base_ls = ls_pulses; base_fe = fe_pulses;
        send_hdr(DI_FS, 16'd0);
        check("t1_fs_pulse", {31'd0, frame_start_o}, 32'd1);
        check("t1_den_fs", {31'd0, decoder_enable_o}, 32'd1);
        for (int l = 1; l <= 3; l++) begin
            send_hdr(DI_RAW10, 16'd8);
            check("t1_ls_pulse", {31'd0, line_start_o}, 32'd1);
            check("t1_lc", {16'd0, line_count_o}, 32'(l));
            send_payload(3);
            check("t1_den_mid", {31'd0, decoder_enable_o}, 32'd1);
        end
        drive(1'b0, '0);
        send_hdr(DI_FE, 16'd0);
        check("t1_fe_pulse", {31'd0, frame_end_o}, 32'd1);
        check("t1_fc", {16'd0, frame_count_o}, 32'd1);
        check("t1_lc_final", {16'd0, line_count_o}, 32'd3);
        check("t1_den_fe", {31'd0, decoder_enable_o}, 32'd0);
        check("t1_err", {28'd0, err_o}, 32'd0);
        check("t1_ls_total", 32'(ls_pulses - base_ls), 32'd3);
        drive(1'b0, '0);
        check("t1_fe_total", 32'(fe_pulses - base_fe), 32'd1);

        // Test 2: decimation by 3, six frames; frames 1 and 4 forwarded
        do_reset();
        enable_i = 1'b1; frame_skip_i = 4'd2; expected_lines_i = 16'd0;
        drive(1'b0, '0);
        for (int f = 1; f <= 6; f++) begin
            logic fwd;
            fwd = ((f - 1) % 3) == 0;
            send_hdr(DI_FS, 16'd0);
            check("t2_fs_pulse", {31'd0, frame_start_o}, {31'd0, fwd});
            check("t2_den_fs", {31'd0, decoder_enable_o}, {31'd0, fwd});
            send_hdr(DI_RAW12, 16'd8);
            send_payload(3);
            check("t2_den_line", {31'd0, decoder_enable_o}, {31'd0, fwd});
            send_hdr(DI_FE, 16'd0);
            check("t2_fe_pulse", {31'd0, frame_end_o}, {31'd0, fwd});
            drive(1'b0, '0);
        end
        check("t2_fc", {16'd0, frame_count_o}, 32'd2);
        check("t2_err", {28'd0, err_o}, 32'd0);

        // Test 3: fake sync + FE DI inside a payload; then enable drop mid-frame
        do_reset();
        enable_i = 1'b1; frame_skip_i = 4'd0; expected_lines_i = 16'd0;
        drive(1'b0, '0);
        send_hdr(DI_FS, 16'd0);
        send_hdr(DI_RAW10, 16'd8);
        check("t3_lc_before", {16'd0, line_count_o}, 32'd1);
        base_fe = fe_pulses;
        drive(1'b1, 32'h0000_00B8);
        drive(1'b1, 32'h0000_0001);
        drive(1'b1, 32'h0000_0000);
        check("t3_state", 32'(state_o), 32'(ST_FRAME));
        check("t3_lc_after", {16'd0, line_count_o}, 32'd1);
        check("t3_no_fe", 32'(fe_pulses - base_fe), 32'd0);
        enable_i = 1'b0;
        send_hdr(DI_RAW10, 16'd0);
        send_payload(1);
        check("t3_en_drop_state", 32'(state_o), 32'(ST_FRAME));
        check("t3_en_drop_lc", {16'd0, line_count_o}, 32'd2);
        send_hdr(DI_FE, 16'd0);
        check("t3_fe_pulse", {31'd0, frame_end_o}, 32'd1);
        check("t3_idle", 32'(state_o), 32'(ST_IDLE));

        // Test 4: truncated WC=16 packet (needs 5 words, burst ends after 4)
        do_reset();
        enable_i = 1'b1; frame_skip_i = 4'd0; expected_lines_i = 16'd0;
        drive(1'b0, '0);
        send_hdr(DI_FS, 16'd0);
        send_hdr(DI_RAW12, 16'd16);
        send_payload(4);
        check("t4_no_err_yet", {28'd0, err_o}, 32'd0);
        drive(1'b0, '0);
        check("t4_trunc", {28'd0, err_o}, 32'b1000);
        drive(1'b0, '0);
        check("t4_sticky", {28'd0, err_o}, 32'b1000);
        clear_err_i = 1'b1;
        drive(1'b0, '0);
        clear_err_i = 1'b0;
        check("t4_cleared", {28'd0, err_o}, 32'd0);
        send_hdr(DI_RAW12, 16'd16);
        send_payload(4);
        clear_err_i = 1'b1;
        drive(1'b0, '0);
        clear_err_i = 1'b0;
        check("t4_set_wins", {28'd0, err_o}, 32'b1000);
        check("t4_lc", {16'd0, line_count_o}, 32'd2);

        // Test 5: FS inside a frame restarts it
        do_reset();
        enable_i = 1'b1; frame_skip_i = 4'd0; expected_lines_i = 16'd1;
        drive(1'b0, '0);
        send_hdr(DI_FS, 16'd0);
        for (int l = 0; l < 2; l++) begin
            send_hdr(DI_RAW10, 16'd8);
            send_payload(3);
        end
        check("t5_lc2", {16'd0, line_count_o}, 32'd2);
        send_hdr(DI_FS, 16'd0);
        check("t5_refs_pulse", {31'd0, frame_start_o}, 32'd1);
        check("t5_refs_err", {28'd0, err_o}, 32'b0001);
        check("t5_refs_lc", {16'd0, line_count_o}, 32'd0);
        check("t5_refs_fc", {16'd0, frame_count_o}, 32'd1);
        send_hdr(DI_RAW10, 16'd8);
        send_payload(3);
        send_hdr(DI_FE, 16'd0);
        check("t5_lc", {16'd0, line_count_o}, 32'd1);
        check("t5_fc", {16'd0, frame_count_o}, 32'd2);
        check("t5_err", {28'd0, err_o}, 32'b0001);

        // Test 6: async reset mid-frame, then FE while waiting for FS
        do_reset();
        enable_i = 1'b1; frame_skip_i = 4'd0; expected_lines_i = 16'd0;
        drive(1'b0, '0);
        send_hdr(DI_FS, 16'd0);
        send_hdr(DI_RAW10, 16'd8);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(posedge clk_i);
        #2;
        reset_n_i = 1'b1;
        data_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("t6_wait_fs", 32'(state_o), 32'(ST_WAIT_FS));
        base_fe = fe_pulses;
        send_hdr(DI_FE, 16'd0);
        check("t6_fe_err", {28'd0, err_o}, 32'b0010);
        check("t6_state", 32'(state_o), 32'(ST_WAIT_FS));
        check("t6_fc", {16'd0, frame_count_o}, 32'd0);
        drive(1'b0, '0);
        check("t6_no_fe", 32'(fe_pulses - base_fe), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
